ps2_keymatrix: RTL

PS/2 keyboard front end for the PC-8001 core. It receives PS/2 device-to-host frames and decodes make/break scan codes, including E0/F0 prefixes. Each decoded key maps onto a 12-row x 8-bit PC-8001 key matrix. The top level reads the matrix through the port 00h-0Bh row address and drives `keydata`; it inverts `keydata` to form the active-low I/O data.

---
 rtl/ps2_keymatrix_pkg.sv | 36 +++
 rtl/ps2_scan_map.sv | 104 ++++++++++
 rtl/ps2_keymatrix.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_keymatrix_pkg.sv
// Shared types and constants for the PS/2 to PC-8001 key matrix front end.
// Optional build macro used by the top level: PS2_PARITY_CHECK_EN.
package ps2_keymatrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_BAT   = 8'hAA;

  typedef struct packed {
    logic       hit;
    logic [3:0] row;
    logic [2:0] col;
  } key_loc_t;

  function automatic key_loc_t make_loc(input logic [3:0] row, input logic [2:0] col);
    key_loc_t loc;
    loc.hit = 1'b1;
    loc.row = row;
    loc.col = col;
    return loc;
  endfunction

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_scan_map.sv
// Scan code set 2 to PC-8001 matrix position lookup; bit 8 of the code is the E0 prefix.
module ps2_scan_map
  import ps2_keymatrix_pkg::*;
(
  input  logic [8:0] i_code,
  output key_loc_t   o_loc
);

  // Table lookup; unlisted codes report no hit.
  always_comb begin
    o_loc = '0;
    case (i_code)
      9'h070: o_loc = make_loc(4'd0, 3'd0);
      9'h069: o_loc = make_loc(4'd0, 3'd1);
      9'h072: o_loc = make_loc(4'd0, 3'd2);
      9'h07A: o_loc = make_loc(4'd0, 3'd3);
      9'h06B: o_loc = make_loc(4'd0, 3'd4);
      9'h073: o_loc = make_loc(4'd0, 3'd5);
      9'h074: o_loc = make_loc(4'd0, 3'd6);
      9'h06C: o_loc = make_loc(4'd0, 3'd7);
      9'h075: o_loc = make_loc(4'd1, 3'd0);
      9'h07D: o_loc = make_loc(4'd1, 3'd1);
      9'h07C: o_loc = make_loc(4'd1, 3'd2);
      9'h079: o_loc = make_loc(4'd1, 3'd3);
      9'h071: o_loc = make_loc(4'd1, 3'd6);
      9'h05A: o_loc = make_loc(4'd1, 3'd7);
      9'h15A: o_loc = make_loc(4'd1, 3'd7);
      9'h00E: o_loc = make_loc(4'd2, 3'd0);
      9'h01C: o_loc = make_loc(4'd2, 3'd1);
      9'h032: o_loc = make_loc(4'd2, 3'd2);
      9'h021: o_loc = make_loc(4'd2, 3'd3);
      9'h023: o_loc = make_loc(4'd2, 3'd4);
      9'h024: o_loc = make_loc(4'd2, 3'd5);
      9'h02B: o_loc = make_loc(4'd2, 3'd6);
      9'h034: o_loc = make_loc(4'd2, 3'd7);
      9'h033: o_loc = make_loc(4'd3, 3'd0);
      9'h043: o_loc = make_loc(4'd3, 3'd1);
      9'h03B: o_loc = make_loc(4'd3, 3'd2);
      9'h042: o_loc = make_loc(4'd3, 3'd3);
      9'h04B: o_loc = make_loc(4'd3, 3'd4);
      9'h03A: o_loc = make_loc(4'd3, 3'd5);
      9'h031: o_loc = make_loc(4'd3, 3'd6);
      9'h044: o_loc = make_loc(4'd3, 3'd7);
      9'h04D: o_loc = make_loc(4'd4, 3'd0);
      9'h015: o_loc = make_loc(4'd4, 3'd1);
      9'h02D: o_loc = make_loc(4'd4, 3'd2);
      9'h01B: o_loc = make_loc(4'd4, 3'd3);
      9'h02C: o_loc = make_loc(4'd4, 3'd4);
      9'h03C: o_loc = make_loc(4'd4, 3'd5);
      9'h02A: o_loc = make_loc(4'd4, 3'd6);
      9'h01D: o_loc = make_loc(4'd4, 3'd7);
      9'h022: o_loc = make_loc(4'd5, 3'd0);
      9'h035: o_loc = make_loc(4'd5, 3'd1);
      9'h01A: o_loc = make_loc(4'd5, 3'd2);
      9'h054: o_loc = make_loc(4'd5, 3'd3);
      9'h05D: o_loc = make_loc(4'd5, 3'd4);
      9'h05B: o_loc = make_loc(4'd5, 3'd5);
      9'h055: o_loc = make_loc(4'd5, 3'd6);
      9'h04E: o_loc = make_loc(4'd5, 3'd7);
      9'h045: o_loc = make_loc(4'd6, 3'd0);
      9'h016: o_loc = make_loc(4'd6, 3'd1);
      9'h01E: o_loc = make_loc(4'd6, 3'd2);
      9'h026: o_loc = make_loc(4'd6, 3'd3);
      9'h025: o_loc = make_loc(4'd6, 3'd4);
      9'h02E: o_loc = make_loc(4'd6, 3'd5);
      9'h036: o_loc = make_loc(4'd6, 3'd6);
      9'h03D: o_loc = make_loc(4'd6, 3'd7);
      9'h03E: o_loc = make_loc(4'd7, 3'd0);
      9'h046: o_loc = make_loc(4'd7, 3'd1);
      9'h052: o_loc = make_loc(4'd7, 3'd2);
      9'h04C: o_loc = make_loc(4'd7, 3'd3);
      9'h041: o_loc = make_loc(4'd7, 3'd4);
      9'h049: o_loc = make_loc(4'd7, 3'd5);
      9'h04A: o_loc = make_loc(4'd7, 3'd6);
      9'h051: o_loc = make_loc(4'd7, 3'd7);
      9'h16C: o_loc = make_loc(4'd8, 3'd0);
      9'h175: o_loc = make_loc(4'd8, 3'd1);
      9'h174: o_loc = make_loc(4'd8, 3'd2);
      9'h171: o_loc = make_loc(4'd8, 3'd3);
      9'h170: o_loc = make_loc(4'd8, 3'd3);
      9'h066: o_loc = make_loc(4'd8, 3'd3);
      9'h011: o_loc = make_loc(4'd8, 3'd4);
      9'h111: o_loc = make_loc(4'd8, 3'd5);
      9'h012: o_loc = make_loc(4'd8, 3'd6);
      9'h059: o_loc = make_loc(4'd8, 3'd6);
      9'h014: o_loc = make_loc(4'd8, 3'd7);
      9'h114: o_loc = make_loc(4'd8, 3'd7);
      9'h007: o_loc = make_loc(4'd9, 3'd0);
      9'h005: o_loc = make_loc(4'd9, 3'd1);
      9'h006: o_loc = make_loc(4'd9, 3'd2);
      9'h004: o_loc = make_loc(4'd9, 3'd3);
      9'h00C: o_loc = make_loc(4'd9, 3'd4);
      9'h003: o_loc = make_loc(4'd9, 3'd5);
      9'h029: o_loc = make_loc(4'd9, 3'd6);
      9'h076: o_loc = make_loc(4'd9, 3'd7);
      9'h00D: o_loc = make_loc(4'd10, 3'd0);
      9'h172: o_loc = make_loc(4'd10, 3'd1);
      9'h16B: o_loc = make_loc(4'd10, 3'd2);
      9'h058: o_loc = make_loc(4'd10, 3'd7);
      default: o_loc = '0;
    endcase
  end

endmodule

// File: rtl/ps2_keymatrix.sv
// PS/2 keyboard receiver and make/break decoder driving a 12-row PC-8001 key matrix.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_keymatrix
  import ps2_keymatrix_pkg::*;
#(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 2048,
  parameter int ROWS     = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [3:0] kbd_adr,
  output logic [7:0] keydata,
  output logic       frame_err
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

`ifdef PS2_PARITY_CHECK_EN
  localparam logic PAR_CHECK = 1'b1;
`else
  localparam logic PAR_CHECK = 1'b0;
`endif

  logic [1:0]    r_clk_sync, r_dat_sync;
  logic [FW-1:0] r_clk_cnt, r_dat_cnt;
  logic          r_clk_filt, r_dat_filt, r_clk_filt_d;
  ps2_state_t    r_state;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift, r_byte;
  logic          r_par, r_byte_valid, r_frame_err;
  logic [WW-1:0] r_wdog;
  logic          r_ext, r_brk;
  logic [7:0]    r_matrix [ROWS];
  logic [7:0]    r_keydata;
  logic          w_fall, w_par_ok;
  key_loc_t      w_loc;

  // Synchronize both lines, then accept a new level only after FILT_LEN agreeing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync   <= 2'b11;
      r_dat_sync   <= 2'b11;
      r_clk_cnt    <= '0;
      r_dat_cnt    <= '0;
      r_clk_filt   <= 1'b1;
      r_dat_filt   <= 1'b1;
      r_clk_filt_d <= 1'b1;
    end else begin
      r_clk_sync   <= {r_clk_sync[0], ps2_clk};
      r_dat_sync   <= {r_dat_sync[0], ps2_data};
      r_clk_filt_d <= r_clk_filt;
      if (r_clk_sync[1] == r_clk_filt) begin
        r_clk_cnt <= '0;
      end else if (r_clk_cnt == FW'(FILT_LEN - 1)) begin
        r_clk_filt <= r_clk_sync[1];
        r_clk_cnt  <= '0;
      end else begin
        r_clk_cnt <= r_clk_cnt + FW'(1);
      end
      if (r_dat_sync[1] == r_dat_filt) begin
        r_dat_cnt <= '0;
      end else if (r_dat_cnt == FW'(FILT_LEN - 1)) begin
        r_dat_filt <= r_dat_sync[1];
        r_dat_cnt  <= '0;
      end else begin
        r_dat_cnt <= r_dat_cnt + FW'(1);
      end
    end
  end

  assign w_fall   = r_clk_filt_d & ~r_clk_filt;
  assign w_par_ok = odd_parity_ok(r_shift, r_par) | ~PAR_CHECK;

  // Frame receiver with inter-edge watchdog; a stalled frame is abandoned as an error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_bitcnt     <= 3'd0;
      r_shift      <= 8'h00;
      r_par        <= 1'b0;
      r_wdog       <= '0;
      r_byte       <= 8'h00;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (r_state != ST_IDLE && !w_fall && r_wdog == WW'(TIMEOUT - 1)) begin
        r_state     <= ST_IDLE;
        r_wdog      <= '0;
        r_frame_err <= 1'b1;
      end else begin
        if (r_state == ST_IDLE || w_fall) begin
          r_wdog <= '0;
        end else begin
          r_wdog <= r_wdog + WW'(1);
        end
        if (w_fall) begin
          case (r_state)
            ST_IDLE: begin
              if (!r_dat_filt) begin
                r_state  <= ST_DATA;
                r_bitcnt <= 3'd0;
              end
            end
            ST_DATA: begin
              r_shift  <= {r_dat_filt, r_shift[7:1]};
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_state <= ST_PARITY;
              end
            end
            ST_PARITY: begin
              r_par   <= r_dat_filt;
              r_state <= ST_STOP;
            end
            ST_STOP: begin
              if (r_dat_filt && w_par_ok) begin
                r_byte_valid <= 1'b1;
                r_byte       <= r_shift;
              end else begin
                r_frame_err <= 1'b1;
              end
              r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  ps2_scan_map u_map (
    .i_code ({r_ext, r_byte}),
    .o_loc  (w_loc)
  );

  // Prefix tracking and matrix update; E1/AA pass through without disturbing pending prefixes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        r_matrix[i] <= 8'h00;
      end
    end else if (r_byte_valid) begin
      case (r_byte)
        SC_EXT: r_ext <= 1'b1;
        SC_BRK: r_brk <= 1'b1;
        SC_PAUSE, SC_BAT: begin
          r_ext <= r_ext;
          r_brk <= r_brk;
        end
        default: begin
          if (w_loc.hit && w_loc.row < 4'(ROWS)) begin
            r_matrix[w_loc.row][w_loc.col] <= ~r_brk;
          end
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      endcase
    end
  end

  // Registered row read; same-cycle updates show up one clock later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_keydata <= 8'h00;
    end else if (kbd_adr < 4'(ROWS)) begin
      r_keydata <= r_matrix[kbd_adr];
    end else begin
      r_keydata <= 8'h00;
    end
  end

  assign keydata   = r_keydata;
  assign frame_err = r_frame_err;

endmodule
